// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: four functional units, round-robin grant, one-cycle broadcast.
// Optional macro CDB_LSU_PRIO_EN gives the LSU (index 3) fixed priority over round-robin.
module cdb_arbiter #(
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          req_valid,
  input  logic [4*TAG_W-1:0]  req_tag,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          req_ready,
  input  logic                flush,
  output logic                cdb_valid,
  output logic [TAG_W-1:0]    cdb_tag,
  output logic [DATA_W-1:0]   cdb_data,
  output logic [1:0]          cdb_src
);

  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;

  logic       gnt_found;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       accept;

  // Search rr_ptr, rr_ptr+1, ... modulo 4; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
`ifdef CDB_LSU_PRIO_EN
    if (req_valid[3]) begin
      gnt_found = 1'b1;
      gnt_idx   = 2'd3;
    end
`endif
  end

  always_comb begin
    req_ready = 4'b0000;
    if (!rst && !flush && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign accept = |req_ready;

  // Flush and reset both suppress req_ready, so accept already covers them.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    cdb_valid_d = accept;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (accept) begin
      rr_ptr_d   = gnt_idx + 2'd1;
      cdb_tag_d  = req_tag[gnt_idx*TAG_W +: TAG_W];
      cdb_data_d = req_data[gnt_idx*DATA_W +: DATA_W];
      cdb_src_d  = gnt_idx;
`ifdef CDB_LSU_PRIO_EN
      if (gnt_idx == 2'd3) begin
        rr_ptr_d = rr_ptr_q;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= 2'd0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= 2'd0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter: reset, rotation, single grant, flush,
// mid-stream reset and LSU/round-robin interplay.
module tb_cdb_arbiter;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned DATA_W = 32;

  logic                clk;
  logic                rst;
  logic [3:0]          req_valid;
  logic [4*TAG_W-1:0]  req_tag;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          req_ready;
  logic                flush;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;

  int passed = 0;
  int total  = 0;

  cdb_arbiter #(
    .TAG_W (TAG_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_tag  (req_tag),
    .req_data (req_data),
    .req_ready(req_ready),
    .flush    (flush),
    .cdb_valid(cdb_valid),
    .cdb_tag  (cdb_tag),
    .cdb_data (cdb_data),
    .cdb_src  (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 4'b1111;
    req_tag   = '0;
    req_data  = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready",    64'(req_ready), 64'h0);
    chk("rst_valid",    64'(cdb_valid), 64'h0);
    chk("rst_tag",      64'(cdb_tag),   64'h0);
    chk("rst_data",     64'(cdb_data),  64'h0);
    chk("rst_src",      64'(cdb_src),   64'h0);
    req_valid = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // Idle for 5 cycles
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_ready", 64'(req_ready), 64'h0);
      chk("idle_valid", 64'(cdb_valid), 64'h0);
    end

    // All four valid: rotation 0,1,2,3,0,1,2,3
    req_tag   = {5'd4, 5'd3, 5'd2, 5'd1};
    req_data  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    req_valid = 4'b1111;
    #1;
    chk("rot_ready0", 64'(req_ready), 64'h1);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rot_valid", 64'(cdb_valid), 64'h1);
      chk("rot_src",   64'(cdb_src),   64'(k % 4));
      chk("rot_tag",   64'(cdb_tag),   64'((k % 4) + 1));
      chk("rot_data",  64'(cdb_data),  64'(32'h1000_0000 + (k % 4)));
      chk("rot_ready", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
    end

    // Only MUL valid
    req_valid = 4'b0100;
    req_tag   = {5'd0, 5'd9, 5'd0, 5'd0};
    req_data  = {32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0};
    #1;
    chk("mul_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = 4'b0000;
    chk("mul_valid", 64'(cdb_valid), 64'h1);
    chk("mul_tag",   64'(cdb_tag),   64'd9);
    chk("mul_data",  64'(cdb_data),  64'hDEAD_BEEF);
    chk("mul_src",   64'(cdb_src),   64'd2);
    step();
    chk("mul_drop_valid", 64'(cdb_valid), 64'h0);
    chk("mul_hold_tag",   64'(cdb_tag),   64'd9);
    chk("mul_hold_data",  64'(cdb_data),  64'hDEAD_BEEF);
    chk("mul_hold_src",   64'(cdb_src),   64'd2);

    // rr_ptr is 3; one LSU grant brings it back to 0
    req_valid = 4'b1000;
    req_tag   = {5'd7, 5'd0, 5'd0, 5'd0};
    #1;
    chk("lsu_ready", 64'(req_ready), 64'h8);
    step();
    chk("lsu_src", 64'(cdb_src), 64'd3);

    // Flush with ALU0/ALU1 pending
    req_valid = 4'b0011;
    req_tag   = {5'd0, 5'd0, 5'd12, 5'd11};
    flush     = 1'b1;
    #1;
    chk("flush_ready", 64'(req_ready), 64'h0);
    step();
    chk("flush_valid", 64'(cdb_valid), 64'h0);
    flush = 1'b0;
    #1;
    chk("post_flush_ready", 64'(req_ready), 64'h1);
    step();
    chk("post_flush_src", 64'(cdb_src),   64'd0);
    chk("post_flush_tag", 64'(cdb_tag),   64'd11);
    req_valid = 4'b0010;
    #1;
    chk("alu1_ready", 64'(req_ready), 64'h2);
    step();
    chk("alu1_valid", 64'(cdb_valid), 64'h1);
    chk("alu1_src",   64'(cdb_src),   64'd1);

    // Asynchronous reset mid-stream while cdb_valid=1 (rr_ptr was 2)
    req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(cdb_valid), 64'h0);
    chk("mid_rst_src",   64'(cdb_src),   64'h0);
    chk("mid_rst_tag",   64'(cdb_tag),   64'h0);
    chk("mid_rst_data",  64'(cdb_data),  64'h0);
    #2 rst = 1'b0;
    req_valid = 4'b1010;
    req_tag   = {5'd21, 5'd0, 5'd20, 5'd0};
    #1;
    chk("rst_rel_ready", 64'(req_ready), 64'h2);
    step();
    chk("rst_rel_src", 64'(cdb_src), 64'd1);
    chk("rst_rel_tag", 64'(cdb_tag), 64'd20);

    // rr_ptr is 2; LSU grant returns it to 0
    req_valid = 4'b1000;
    step();
    chk("lsu2_src", 64'(cdb_src), 64'd3);

    // ALU0 and LSU held for 3 cycles
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("alu0_lsu_valid", 64'(cdb_valid), 64'h1);
`ifdef CDB_LSU_PRIO_EN
      chk("alu0_lsu_src", 64'(cdb_src), 64'd3);
`else
      chk("alu0_lsu_src", 64'(cdb_src), (k == 1) ? 64'd3 : 64'd0);
`endif
    end
    req_valid = 4'b0000;
    step();
    chk("final_idle_valid", 64'(cdb_valid), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 The block SHALL have parameter TAG_W, default 5, meaning the ROB tag width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the result data width.
REQ-003 The block SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  4  result-ready strobe per functional unit; index 0=ALU0, 1=ALU1, 2=MUL, 3=LSU.
REQ-006 The block SHALL have port req_tag  input  4*TAG_W  ROB tag per requester; requester i occupies bits [i*TAG_W +: TAG_W].
REQ-007 The block SHALL have port req_data  input  4*DATA_W  result per requester; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_ready  output  4  one-hot-or-zero grant; requester i's result is accepted on an edge where req_valid[i] and req_ready[i] are both 1.
REQ-009 The block SHALL have port flush  input  1  pipeline flush from the branch/exception unit.
REQ-010 The block SHALL have port cdb_valid  output  1  common data bus broadcast valid.
REQ-011 The block SHALL have port cdb_tag  output  TAG_W  broadcast ROB tag.
REQ-012 The block SHALL have port cdb_data  output  DATA_W  broadcast result.
REQ-013 The block SHALL have port cdb_src  output  2  index of the requester that produced the broadcast.

Function
REQ-014 req_ready SHALL be combinational from req_valid, flush and the round-robin pointer rr_ptr (2 bits); at most one bit SHALL be 1.
REQ-015 With flush=0, the granted requester SHALL be the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo 4.
REQ-016 req_ready[i] SHALL NOT be 1 when req_valid[i]=0; req_ready SHALL be all 0 when flush=1 or req_valid=0.
REQ-017 On an edge with a grant to i, rr_ptr SHALL become (i+1) mod 4; with no grant, rr_ptr SHALL hold.
REQ-018 Latency SHALL be one cycle: an accepted result appears on cdb_valid/tag/data/src in the cycle after acceptance, for exactly one cycle.
REQ-019 The CDB has no backpressure; the block SHALL accept at most one result per cycle, giving 100% bus utilisation when any request is pending.
REQ-020 Requesters SHALL hold req_valid, req_tag and req_data stable until accepted; the block SHALL NOT latch ungranted requests.
REQ-021 On an edge with flush=1, cdb_valid SHALL become 0, no result SHALL be accepted, and rr_ptr SHALL hold.
REQ-022 When cdb_valid=0, cdb_tag, cdb_data and cdb_src SHALL hold their previous values.
REQ-023 When all four requesters are continuously valid, grants SHALL rotate 0,1,2,3,0,... from rr_ptr, so no requester waits more than 3 cycles.

Reset
REQ-024 Asserting rst SHALL immediately, without a clock edge, set cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0 and rr_ptr=0.
REQ-025 While rst=1, req_ready SHALL be all 0.
REQ-026 Reset asserted mid-operation SHALL discard the pending broadcast; the first grant after release SHALL search from index 0.

Configuration
REQ-027 With macro CDB_LSU_PRIO_EN defined, a valid LSU request (index 3) SHALL always be granted ahead of the round-robin winner, and rr_ptr SHALL NOT change on LSU grants.
REQ-028 Without CDB_LSU_PRIO_EN, all four requesters SHALL be arbitrated by pure round-robin as in REQ-015 and REQ-017.

Verification
REQ-029 Reset, then req_valid=4'b0000 for 5 cycles -> req_ready=0, cdb_valid=0, rr_ptr=0.
REQ-030 req_valid=4'b1111 held 8 cycles, tags 1,2,3,4 -> cdb_src sequence 0,1,2,3,0,1,2,3 starting one cycle after the first edge, cdb_valid=1 every cycle.
REQ-031 Only MUL valid, tag 5'd9, data 32'hDEAD_BEEF -> req_ready=4'b0100 the same cycle; next cycle cdb_valid=1, cdb_tag=9, cdb_data=DEADBEEF, cdb_src=2; the following cycle cdb_valid=0.
REQ-032 req_valid=4'b0011 with flush=1 for 1 cycle -> req_ready=0, cdb_valid=0 next cycle; after flush drops, ALU0 is granted first (rr_ptr unchanged at 0).
REQ-033 rst pulsed mid-stream while cdb_valid=1 -> cdb_valid falls asynchronously; after release with req_valid=4'b1010, the first grant goes to index 1.
REQ-034 With CDB_LSU_PRIO_EN and req_valid=4'b1001 held 3 cycles -> cdb_src=3,3,3 and ALU0 is starved; without the macro -> cdb_src=0,3,0.
